// File: rtl/fmc_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmc_cap_pkg
// Description : Shared definitions for the FMC ADC capture block: FSM state
//               encoding, ctrl_word and status bit positions, sample width
//               and the capture-length clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fmc_cap_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // ADC sample width
    localparam int c_sample_w = 12;

    // ctrl_word bit positions
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_abort = 1;
    localparam int c_ctrl_slope = 2;

    // status bit positions
    localparam int c_stat_armed     = 0;
    localparam int c_stat_capturing = 1;
    localparam int c_stat_done      = 2;
    localparam int c_stat_overflow  = 3;

    // Requested length clamped to the buffer; zero selects the full buffer
    function automatic logic [15:0] eff_len(input logic [15:0] len,
                                            input logic [15:0] depth);
        return ((len == 16'd0) || (len > depth)) ? depth : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmc_cap_if.sv
`default_nettype none
// ============================================================================
// Module      : fmc_cap_if
// Description : Bus bundle between the STM32/FMC/ADC side (master) and the
//               capture block (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fmc_cap_if;
    import fmc_cap_pkg::*;

    logic [c_sample_w-1:0] adc_data;
    logic                  adc_valid;
    logic [15:0]           ctrl_word;
    logic [15:0]           len_word;
    logic [c_sample_w-1:0] trig_level;
    logic [15:0]           addr;
    logic                  fmc_rd_en;
    logic [15:0]           sample_out;
    logic [15:0]           status;
    logic [15:0]           cap_count;

    modport master (
        output adc_data, adc_valid, ctrl_word, len_word, trig_level, addr, fmc_rd_en,
        input  sample_out, status, cap_count
    );

    modport slave (
        input  adc_data, adc_valid, ctrl_word, len_word, trig_level, addr, fmc_rd_en,
        output sample_out, status, cap_count
    );

endinterface
`default_nettype wire

// File: rtl/fmc_cap_ram.sv
`default_nettype none
// ============================================================================
// Module      : fmc_cap_ram
// Description : Simple dual-port synchronous RAM, one write port and one
//               registered read port. No reset on the array or read register
//               so it maps onto block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module fmc_cap_ram
    import fmc_cap_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = c_sample_w,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             i_wr_en,
    input  wire logic [AW-1:0]    i_wr_addr,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic [AW-1:0]    i_rd_addr,
    output logic      [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/fmc_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : fmc_adc_capture
// Description : ADC sample capture buffer controlled by an STM32 over FMC.
//               Start arms a capture, the first accepted sample begins it and
//               the latched length ends it. The MCU drains the buffer with
//               reads of RD_DATA_ADDR; each synchronised fmc_rd_en falling
//               edge advances the read pointer.
//               Build option: define FMC_CAP_TRIG_EN to make ARMED wait for a
//               level crossing of trig_level in the ctrl_word slope direction;
//               otherwise the next sample after arming starts the capture.
// Revision    : 1.0 - initial release
// ============================================================================
module fmc_adc_capture
    import fmc_cap_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [15:0] RD_DATA_ADDR = 16'h0002
) (
    input  wire logic clk,
    input  wire logic rst,
    fmc_cap_if.slave  bus
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [15:0]     c_depth   = 16'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    cap_state_t            r_state;
    logic                  r_start_d;
    logic [c_aw-1:0]       r_wptr;
    logic [c_aw-1:0]       r_rptr;
    logic [15:0]           r_cap_count;
    logic [15:0]           r_len;
    logic                  r_overflow;
    logic                  r_rd_s1;
    logic                  r_rd_s2;
    logic                  r_rd_s3;
    logic [15:0]           r_sample_out;

    logic [c_sample_w-1:0] w_ram_q;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_arm;
    logic                  w_trig;
    logic                  w_wr_en;
    logic                  w_pop;
    logic [15:0]           w_cnt_next;
    logic [15:0]           w_status;

    assign w_start    = bus.ctrl_word[c_ctrl_start] & ~r_start_d;
    assign w_abort    = bus.ctrl_word[c_ctrl_abort];
    // Start only re-arms from IDLE or DONE, and abort overrides it
    assign w_arm      = w_start & ~w_abort &
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_next = r_cap_count + 16'd1;

    // The triggering sample in ARMED is stored, as is every sample in CAPTURE
    assign w_wr_en = bus.adc_valid & ~w_abort &
                     (((r_state == ST_ARMED) & w_trig) | (r_state == ST_CAPTURE));

    // Pop on the synchronised falling edge of the read strobe at the data address
    assign w_pop = r_rd_s3 & ~r_rd_s2 & (bus.addr == RD_DATA_ADDR);

`ifdef FMC_CAP_TRIG_EN
    logic [c_sample_w-1:0] r_prev;
    logic                  r_prev_vld;
    logic                  w_unused_ok;

    // Remember the previous sample; history restarts at each arm so a crossing
    // needs two samples taken after start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (w_arm) begin
            r_prev_vld <= 1'b0;
        end else if (bus.adc_valid) begin
            r_prev     <= bus.adc_data;
            r_prev_vld <= 1'b1;
        end
    end

    assign w_trig = r_prev_vld &
                    (bus.ctrl_word[c_ctrl_slope]
                        ? ((r_prev <  bus.trig_level) && (bus.adc_data >= bus.trig_level))
                        : ((r_prev >= bus.trig_level) && (bus.adc_data <  bus.trig_level)));
    assign w_unused_ok = ^bus.ctrl_word[15:3];
`else
    logic w_unused_ok;

    assign w_trig      = 1'b1;
    assign w_unused_ok = ^{bus.ctrl_word[15:2], bus.trig_level};
`endif

    // Capture FSM: arming, write pointer, sample count and latched length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_wptr      <= '0;
            r_cap_count <= '0;
            r_len       <= '0;
        end else begin
            r_start_d <= bus.ctrl_word[c_ctrl_start];
            if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_start) begin
                            r_state     <= ST_ARMED;
                            r_wptr      <= '0;
                            r_cap_count <= '0;
                            r_len       <= eff_len(bus.len_word, c_depth);
                        end
                    end
                    ST_ARMED, ST_CAPTURE: begin
                        if (w_wr_en) begin
                            r_wptr      <= r_wptr + c_ptr_one;
                            r_cap_count <= w_cnt_next;
                            r_state     <= (w_cnt_next == r_len) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read side: strobe synchroniser, read pointer and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_s1    <= 1'b0;
            r_rd_s2    <= 1'b0;
            r_rd_s3    <= 1'b0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_s1 <= bus.fmc_rd_en;
            r_rd_s2 <= r_rd_s1;
            r_rd_s3 <= r_rd_s2;
            if (w_arm) begin
                r_rptr     <= '0;
                r_overflow <= 1'b0;
            end else if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
                if (16'(r_rptr) == r_cap_count) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    fmc_cap_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_sample_w),
        .AW    (c_aw)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_data (bus.adc_data),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_ram_q)
    );

    // Output register for the read data so sample_out resets to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample_out <= '0;
        end else begin
            r_sample_out <= {{(16 - c_sample_w){1'b0}}, w_ram_q};
        end
    end

    // Status word decoded from the state and overflow registers
    always_comb begin
        w_status                   = '0;
        w_status[c_stat_armed]     = (r_state == ST_ARMED);
        w_status[c_stat_capturing] = (r_state == ST_CAPTURE);
        w_status[c_stat_done]      = (r_state == ST_DONE);
        w_status[c_stat_overflow]  = r_overflow;
    end

    assign bus.sample_out = r_sample_out;
    assign bus.status     = w_status;
    assign bus.cap_count  = r_cap_count;

endmodule
`default_nettype wire

// File: doc/fmc_adc_capture.md
FMC_ADC_CAPTURE -- requirements
Module: fmc_adc_capture

Interface
REQ-001 Parameter DEPTH, default 1024; capture buffer depth in samples, power of two.
REQ-002 Parameter RD_DATA_ADDR, default 16'h0002; FMC address whose read pops one sample.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 adc_data  input  12  ADC sample, valid when adc_valid=1.
REQ-006 adc_valid  input  1  sample strobe, one cycle per sample.
REQ-007 ctrl_word  input  16  STM32 control register; bit0 start, bit1 abort, bit2 trig_slope (1=rising).
REQ-008 len_word  input  16  requested capture length; 0 means DEPTH.
REQ-009 trig_level  input  12  trigger threshold.
REQ-010 addr  input  16  latched FMC address.
REQ-011 fmc_rd_en  input  1  FMC read strobe, asynchronous to clk.
REQ-012 sample_out  output  16  buffer word at read pointer, zero-extended.
REQ-013 status  output  16  {12'b0, overflow, done, capturing, armed}.
REQ-014 cap_count  output  16  samples written in current/last capture.

Function
REQ-015 FSM states IDLE, ARMED, CAPTURE, DONE; IDLE after reset.
REQ-016 Start = rising edge of ctrl_word[0] (registered compare); a held level does not restart.
REQ-017 IDLE or DONE + start -> ARMED; write pointer, read pointer, cap_count cleared; effective length latched as min(len_word, DEPTH), 0 -> DEPTH.
REQ-018 ARMED -> CAPTURE on trigger condition (see Configuration); the triggering sample is the first stored.
REQ-019 CAPTURE: each adc_valid writes adc_data at write pointer, increments pointer and cap_count same cycle.
REQ-020 CAPTURE -> DONE on the cycle the latched length-th sample is written; no further writes.
REQ-021 ctrl_word[1]=1 in any state -> IDLE next cycle; cap_count and buffer retained; abort wins over simultaneous start.
REQ-022 Start while ARMED or CAPTURE is ignored.
REQ-023 fmc_rd_en passes a 2-flop synchroniser; its synchronised falling edge with addr==RD_DATA_ADDR increments read pointer by one.
REQ-024 Read pointer wraps DEPTH-1 -> 0; reads allowed in any state.
REQ-025 overflow sets when a pop occurs with read pointer == cap_count (reading beyond captured data); cleared by start.
REQ-026 sample_out reflects memory at read pointer within 2 cycles of a pointer change (synchronous RAM read, registered).

Reset
REQ-027 rst low: state IDLE; all pointers, cap_count, status, sample_out = 0; synchroniser and edge registers = 0.
REQ-028 Reset mid-capture aborts without further writes; buffer contents undefined.

Configuration
REQ-029 Macro FMC_CAP_TRIG_EN defined: ARMED waits for a level crossing on adc_valid samples -- previous < trig_level <= current if trig_slope=1, previous >= trig_level > current if trig_slope=0.
REQ-030 FMC_CAP_TRIG_EN undefined: ARMED -> CAPTURE on the next adc_valid unconditionally; trig_level and trig_slope ignored.

Structure
REQ-031 Shared package fmc_cap_pkg holds FSM state encoding, status bit positions, ctrl_word bit positions.
REQ-032 One sub-module: fmc_cap_ram, simple dual-port synchronous RAM, DEPTH x 12.

Verification
REQ-033 len_word=8, start, 10 adc_valid with ramp 0..9 (trigger disabled) -> cap_count=8, done=1, buffer holds 0..7.
REQ-034 After REQ-033 case, 9 FMC reads at addr 0x0002 -> sample_out 0..7 then overflow=1.
REQ-035 FMC_CAP_TRIG_EN, trig_level=100, slope rising, samples 50,90,120,130 -> first stored 120.
REQ-036 Abort (ctrl_word=0x0003) during CAPTURE after 3 samples -> IDLE next cycle, cap_count=3, armed=capturing=0.
REQ-037 len_word=0 -> capture of 1024 samples, read pointer wraps 1023 -> 0 after 1024 pops.
REQ-038 rst asserted mid-capture -> all outputs 0 immediately, IDLE after release.
